// File: rtl/cim_mac_array.sv
// Compute-in-memory dot-product engine: parallel signed multiply, pipelined adder tree, start/done handshake.
// Define CIM_MAC_ARRAY_SAT_EN to build saturating adder-tree levels; default build wraps modulo 2^ACC_WIDTH.
module cim_mac_array #(
    parameter int MAC_COUNT  = 256,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] input_data  [0:MAC_COUNT-1],
    input  logic signed [DATA_WIDTH-1:0] weight_data [0:MAC_COUNT-1],
    input  logic                         start,
    output logic                         done,
    output logic signed [ACC_WIDTH-1:0]  result
);

    localparam int LEVELS = $clog2(MAC_COUNT);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int CNT_W  = $clog2(LEVELS + 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEVELS + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          done_q, done_d;
    logic signed [ACC_WIDTH-1:0]   result_q, result_d;
    logic                          capture;
    logic                          advance;

    logic signed [DATA_WIDTH-1:0]  op_a_q [0:MAC_COUNT-1];
    logic signed [DATA_WIDTH-1:0]  op_b_q [0:MAC_COUNT-1];
    logic signed [PROD_W-1:0]      prod_q [0:MAC_COUNT-1];
    logic signed [PROD_W-1:0]      prod_d [0:MAC_COUNT-1];
    // Heap-ordered tree: node i sums children 2i and 2i+1; node 1 is the root.
    logic signed [ACC_WIDTH-1:0]   node_q [1:MAC_COUNT-1];
    logic signed [ACC_WIDTH-1:0]   node_d [1:MAC_COUNT-1];

    function automatic logic signed [PROD_W-1:0] mul_full(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return PROD_W'(a) * PROD_W'(b);
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sext_prod(
        input logic signed [PROD_W-1:0] p
    );
        return ACC_WIDTH'(p);
    endfunction

`ifdef CIM_MAC_ARRAY_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // One extra bit of headroom exposes overflow, which is then clamped.
    function automatic logic signed [ACC_WIDTH-1:0] add_lvl(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
        logic signed [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
        return s[ACC_WIDTH-1:0];
    endfunction
`else
    function automatic logic signed [ACC_WIDTH-1:0] add_lvl(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
        return a + b;
    endfunction
`endif

    for (genvar i = 0; i < MAC_COUNT; i++) begin : g_mul
        assign prod_d[i] = mul_full(op_a_q[i], op_b_q[i]);
    end

    for (genvar i = 1; i < MAC_COUNT; i++) begin : g_node
        if (2 * i >= MAC_COUNT) begin : g_leaf
            assign node_d[i] = add_lvl(sext_prod(prod_q[2*i-MAC_COUNT]),
                                       sext_prod(prod_q[2*i+1-MAC_COUNT]));
        end else begin : g_inner
            assign node_d[i] = add_lvl(node_q[2*i], node_q[2*i+1]);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        capture  = 1'b0;
        advance  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                advance = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                // The root settled on the previous edge; publish it and free the engine.
                if (cnt_q == LAST_CNT) begin
                    done_d   = 1'b1;
                    result_d = node_q[1];
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAC_COUNT; i++) begin
                op_a_q[i] <= '0;
                op_b_q[i] <= '0;
                prod_q[i] <= '0;
            end
            for (int i = 1; i < MAC_COUNT; i++) begin
                node_q[i] <= '0;
            end
        end else begin
            if (capture) begin
                for (int i = 0; i < MAC_COUNT; i++) begin
                    op_a_q[i] <= input_data[i];
                    op_b_q[i] <= weight_data[i];
                end
            end
            if (advance) begin
                prod_q <= prod_d;
                node_q <= node_d;
            end
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_cim_mac_array.sv
// Scoreboard bench for cim_mac_array (default wrap-around build, 256 lanes).
module tb_cim_mac_array;

    localparam int N = 256;

    logic                clk;
    logic                rst_n;
    logic signed [7:0]   in_d [0:N-1];
    logic signed [7:0]   w_d  [0:N-1];
    logic                start;
    logic                done;
    logic signed [31:0]  result;

    logic signed [31:0]  sb [$];
    int                  checks;
    int                  errors;

    cim_mac_array #(.MAC_COUNT(N), .DATA_WIDTH(8), .ACC_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .input_data  (in_d),
        .weight_data (w_d),
        .start       (start),
        .done        (done),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic fill(input int a, input int b, input int lanes);
        for (int i = 0; i < N; i++) begin
            in_d[i] = (i < lanes) ? 8'(a) : 8'sd0;
            w_d[i]  = (i < lanes) ? 8'(b) : 8'sd0;
        end
    endtask

    function automatic logic signed [31:0] model_dot();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += int'(in_d[i]) * int'(w_d[i]);
        return 32'(s);
    endfunction

    // Pulse start for exactly one rising edge; optionally record the expected result.
    task automatic launch(input bit push, input logic signed [31:0] exp);
        @(negedge clk);
        if (push) sb.push_back(exp);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        fill(0, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++;
        if (result !== 32'sd0) begin errors++; $display("FAIL reset_result got=%0d exp=0", result); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL idle_done got=%b exp=0", done); end
    endtask

    task automatic test_pattern(input string name, input int a, input int b, input int lanes,
                                input logic signed [31:0] exp);
        int n;
        bit seen;
        logic signed [31:0] e;
        fill(a, b, lanes);
        launch(1'b1, exp);
        wait_done(n, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || n != 10) begin
            errors++; $display("FAIL %s_latency got=%0d seen=%b exp=10", name, n, seen);
        end
        checks++;
        if (result !== e) begin errors++; $display("FAIL %s_result got=%0d exp=%0d", name, result, e); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== e) begin
            errors++; $display("FAIL %s_hold done=%b result=%0d exp=%0d", name, done, result, e);
        end
    endtask

    task automatic test_ramp();
        int n;
        bit seen;
        logic signed [31:0] e;
        fill(0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            in_d[i] = 8'(i);
            w_d[i]  = 8'(i);
        end
        launch(1'b1, 32'sd1240);
        wait_done(n, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || n != 10) begin errors++; $display("FAIL ramp_latency got=%0d exp=10", n); end
        checks++;
        if (result !== e) begin errors++; $display("FAIL ramp_result got=%0d exp=%0d", result, e); end
    endtask

    task automatic test_busy_restart();
        int dones;
        int done_at;
        logic signed [31:0] e;
        fill(0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            in_d[i] = 8'(i);
            w_d[i]  = 8'(i);
        end
        launch(1'b1, 32'sd1240);
        dones = 0;
        done_at = 0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 2) begin
                fill(1, 1, N);
                start = 1'b1;
            end
            if (c == 3) start = 1'b0;
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                if (done_at == 0) begin
                    done_at = c;
                    e = sb.pop_front();
                    checks++;
                    if (result !== e) begin
                        errors++; $display("FAIL busy_restart_result got=%0d exp=%0d", result, e);
                    end
                end
            end
        end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL busy_restart_dones got=%0d exp=1", dones); end
        checks++;
        if (done_at != 10) begin errors++; $display("FAIL busy_restart_latency got=%0d exp=10", done_at); end
    endtask

    task automatic test_midreset();
        int dones;
        int n;
        bit seen;
        logic signed [31:0] e;
        fill(3, 7, N);
        launch(1'b0, 32'sd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || result !== 32'sd0) begin
            errors++; $display("FAIL midreset_clear done=%b result=%0d exp=0", done, result);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin errors++; $display("FAIL midreset_no_done got=%0d exp=0", dones); end
        checks++;
        if (result !== 32'sd0) begin errors++; $display("FAIL midreset_result got=%0d exp=0", result); end
        fill(1, 1, N);
        launch(1'b1, 32'sd256);
        wait_done(n, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || n != 10 || result !== e) begin
            errors++; $display("FAIL midreset_fresh n=%0d result=%0d exp=%0d", n, result, e);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit seen;
        logic signed [31:0] e;
        logic signed [31:0] prev;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            in_d[i] = 8'($urandom_range(0, 255));
            w_d[i]  = 8'($urandom_range(0, 255));
        end
        sb.push_back(model_dot());
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done(n, seen);
            e = sb.pop_front();
            checks++;
            if (!seen || n != ((k == 0) ? 11 : 10)) begin
                errors++; $display("FAIL b2b_latency op=%0d got=%0d seen=%b", k, n, seen);
            end
            checks++;
            if (result !== e) begin errors++; $display("FAIL b2b_result op=%0d got=%0d exp=%0d", k, result, e); end
            prev = e;
            if (k < 2) begin
                for (int i = 0; i < N; i++) begin
                    in_d[i] = 8'($urandom_range(0, 255));
                    w_d[i]  = 8'($urandom_range(0, 255));
                end
                sb.push_back(model_dot());
                @(negedge clk);
                checks++;
                if (done !== 1'b0 || result !== prev) begin
                    errors++; $display("FAIL b2b_hold op=%0d done=%b result=%0d exp=%0d", k, done, result, prev);
                end
            end else begin
                start = 1'b0;
            end
        end
        repeat (15) @(negedge clk);
        checks++;
        if (sb.size() != 0 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_drain pending=%0d done=%b exp=0", sb.size(), done);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_pattern("all_ones", 1, 1, N, 32'sd256);
        test_ramp();
        test_pattern("neg_mix", 10, -5, 8, -32'sd400);
        test_pattern("max_pos", -128, -128, N, 32'sd4194304);
        test_pattern("max_neg", -128, 127, N, -32'sd4161536);
        test_busy_restart();
        test_midreset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
